load_align_unit: RTL and testbench



---
 rtl/load_align_pkg.sv | 59 +++++
 rtl/load_extract.sv | 61 ++++++
 rtl/load_align_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_load_align_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_align_pkg.sv
// -----------------------------------------------------------------------------
// load_align_pkg
// Shared definitions for the load alignment unit:
//   - width-code constants carried on req_width
//   - FSM state encoding used by load_align_unit
//   - size_of()   : number of bytes a width code loads on a bus of bus_bytes
//   - is_signed() : whether a width code sign-extends its result
// Optional feature macro used by the unit: LOAD_ALIGN_SPLIT_EN.
// -----------------------------------------------------------------------------
package load_align_pkg;

  // Width codes presented on req_width.
  localparam logic [2:0] MEM_NO     = 3'b000;  // full bus width, unsigned
  localparam logic [2:0] MEM_DOUBLE = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_HALF   = 3'b011;
  localparam logic [2:0] MEM_BYTE   = 3'b100;
  localparam logic [2:0] MEM_UNWORD = 3'b101;
  localparam logic [2:0] MEM_UNHALF = 3'b110;
  localparam logic [2:0] MEM_UNBYTE = 3'b111;

  // Controller states. REQ1/WAIT1 only get used when split loads are built.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Bytes loaded by a width code. MEM_NO means "whole bus word", so the bus
  // width has to be supplied by the caller.
  function automatic logic [3:0] size_of(input logic [2:0] width,
                                         input logic [3:0] bus_bytes);
    logic [3:0] size;
    case (width)
      MEM_NO:                 size = bus_bytes;
      MEM_DOUBLE:             size = 4'd8;
      MEM_WORD, MEM_UNWORD:   size = 4'd4;
      MEM_HALF, MEM_UNHALF:   size = 4'd2;
      MEM_BYTE, MEM_UNBYTE:   size = 4'd1;
      default:                size = bus_bytes;
    endcase
    return size;
  endfunction

  // Signed codes are double/word/half/byte; MEM_NO and the MEM_UN* codes
  // zero-extend.
  function automatic logic is_signed(input logic [2:0] width);
    logic sgn;
    case (width)
      MEM_DOUBLE, MEM_WORD, MEM_HALF, MEM_BYTE: sgn = 1'b1;
      default:                                  sgn = 1'b0;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational byte extraction for the load alignment unit. The two captured
// bus beats are concatenated as {hi, lo}, shifted right by 8*off, trimmed to the
// number of bytes the width code asks for and then sign- or zero-extended.
//
// Ports:
//   hi_i    [DATA_W-1:0]  upper beat (zero when the load did not straddle)
//   lo_i    [DATA_W-1:0]  lower beat
//   off_i   [OFF_W-1:0]   byte offset of the load within the lower beat
//   width_i [2:0]         width code
//   data_o  [DATA_W-1:0]  aligned, extended result
// -----------------------------------------------------------------------------
module load_extract
  import load_align_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [2:0]        width_i,
  output logic [DATA_W-1:0] data_o
);

  logic [2*DATA_W-1:0] both_s;
  logic [2*DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0]   low_s;
  logic [3:0]          size_s;
  logic                msb_s;
  logic                sign_s;

  // Shift the byte stream into place, then fill every byte above the loaded
  // size with the extension byte.
  always_comb begin
    both_s    = {hi_i, lo_i};
    shifted_s = both_s >> {off_i, 3'b000};
    low_s     = shifted_s[DATA_W-1:0];
    size_s    = size_of(width_i, 4'(BYTES));
    // Top bit of the loaded field; a full-width load keeps the bus MSB,
    // which also covers sizes that cannot occur on this bus width.
    case (size_s)
      4'd1:    msb_s = low_s[7];
      4'd2:    msb_s = low_s[15];
      4'd4:    msb_s = low_s[31];
      default: msb_s = low_s[DATA_W-1];
    endcase
    sign_s = msb_s & is_signed(width_i);
    data_o = {DATA_W{1'b0}};
    for (int i = 0; i < BYTES; i++) begin
      if (i < int'(size_s)) begin
        data_o[8*i +: 8] = low_s[8*i +: 8];
      end else begin
        data_o[8*i +: 8] = {8{sign_s}};
      end
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
// Sequential load alignment stage. Accepts one load request (byte address plus
// width code), issues one aligned bus read (two when the load straddles a bus
// word), merges the beats, extracts and extends the result and returns it on a
// valid/ready handshake. Only one load is in flight at a time.
//
// Optional feature macro: LOAD_ALIGN_SPLIT_EN
//   defined   : straddling loads are served with a second read (REQ1/WAIT1)
//   undefined : straddling loads are rejected with rsp_err and no bus access
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_addr  [ADDR_W-1:0]        byte address of the load
//   req_width [2:0]               width code (see load_align_pkg)
//   mem_req_valid/mem_req_ready   bus read request handshake
//   mem_req_addr [ADDR_W-1:0]     bus-word aligned read address
//   mem_rsp_valid                 read data valid (only honoured in WAIT states)
//   mem_rsp_data [DATA_W-1:0]     read data, little-endian
//   rsp_valid/rsp_ready           result handshake
//   rsp_data  [DATA_W-1:0]        aligned, extended result (0 on error)
//   rsp_err                       request was illegal
// -----------------------------------------------------------------------------
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_width,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int         BYTES   = DATA_W / 8;
  localparam int         OFF_W   = $clog2(BYTES);
  localparam logic [4:0] BYTES_L = 5'(BYTES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q,        state_d;
  logic [ADDR_W-1:0]   addr_q,         addr_d;        // aligned first-beat address
  logic [2:0]          width_q,        width_d;
  logic [OFF_W-1:0]    off_q,          off_d;
  logic [DATA_W-1:0]   lo_q,           lo_d;
`ifdef LOAD_ALIGN_SPLIT_EN
  logic                split_q,        split_d;
  logic [DATA_W-1:0]   hi_q,           hi_d;
`endif
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0]   rsp_data_q,     rsp_data_d;
  logic                rsp_err_q,      rsp_err_d;
  logic                req_ready_q;
  logic                mem_req_valid_q;
  logic                rsp_valid_q;

  // Request decode
  logic [OFF_W-1:0]    req_off_s;
  logic [3:0]          req_size_s;
  logic [4:0]          req_span_s;
  logic [ADDR_W-1:0]   req_aligned_s;
  logic                req_illegal_s;
`ifdef LOAD_ALIGN_SPLIT_EN
  logic                req_split_s;
`endif

  // Extraction inputs/outputs
  logic [DATA_W-1:0]   ext_hi_s;
  logic [DATA_W-1:0]   ext_lo_s;
  logic [DATA_W-1:0]   ext_data_s;

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

  // Classify the incoming request: offset, size, straddle and legality.
  always_comb begin
    req_off_s     = req_addr[OFF_W-1:0];
    req_size_s    = size_of(req_width, 4'(BYTES));
    req_span_s    = 5'(req_off_s) + 5'(req_size_s);
    req_aligned_s = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LOAD_ALIGN_SPLIT_EN
    req_split_s   = (req_span_s > BYTES_L);
    // Only a load wider than the bus can never be served.
    req_illegal_s = (5'(req_size_s) > BYTES_L);
`else
    // Without the second read any straddle is unserviceable; this also
    // covers a load wider than the bus since off >= 0.
    req_illegal_s = (req_span_s > BYTES_L);
`endif
  end

  // Feed the extractor straight from the bus in the capturing WAIT state so
  // the result can be registered in the same cycle the last beat arrives.
  always_comb begin
    if (state_q == ST_WAIT0) begin
      ext_lo_s = mem_rsp_data;
    end else begin
      ext_lo_s = lo_q;
    end
`ifdef LOAD_ALIGN_SPLIT_EN
    if (state_q == ST_WAIT1) begin
      ext_hi_s = mem_rsp_data;
    end else begin
      ext_hi_s = hi_q;
    end
`else
    ext_hi_s = {DATA_W{1'b0}};
`endif
  end

  load_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .hi_i    (ext_hi_s),
    .lo_i    (ext_lo_s),
    .off_i   (off_q),
    .width_i (width_q),
    .data_o  (ext_data_s)
  );

  // Next-state and datapath update logic of the load controller.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    width_d        = width_q;
    off_d          = off_q;
    lo_d           = lo_q;
`ifdef LOAD_ALIGN_SPLIT_EN
    split_d        = split_q;
    hi_d           = hi_q;
`endif
    mem_req_addr_d = mem_req_addr_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_aligned_s;
          width_d = req_width;
          off_d   = req_off_s;
          lo_d    = {DATA_W{1'b0}};
`ifdef LOAD_ALIGN_SPLIT_EN
          split_d = req_split_s;
          hi_d    = {DATA_W{1'b0}};
`endif
          if (req_illegal_s) begin
            state_d    = ST_RESP;
            rsp_data_d = {DATA_W{1'b0}};
            rsp_err_d  = 1'b1;
          end else begin
            state_d        = ST_REQ0;
            mem_req_addr_d = req_aligned_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ0: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT0;
        end else begin
          state_d = ST_REQ0;
        end
      end

      ST_WAIT0: begin
        if (mem_rsp_valid) begin
          lo_d = mem_rsp_data;
`ifdef LOAD_ALIGN_SPLIT_EN
          if (split_q) begin
            state_d        = ST_REQ1;
            // Next bus word; wraps at the top of the address space.
            mem_req_addr_d = addr_q + ADDR_W'(BYTES);
          end else begin
            state_d    = ST_RESP;
            rsp_data_d = ext_data_s;
            rsp_err_d  = 1'b0;
          end
`else
          state_d    = ST_RESP;
          rsp_data_d = ext_data_s;
          rsp_err_d  = 1'b0;
`endif
        end else begin
          state_d = ST_WAIT0;
        end
      end

`ifdef LOAD_ALIGN_SPLIT_EN
      ST_REQ1: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT1;
        end else begin
          state_d = ST_REQ1;
        end
      end

      ST_WAIT1: begin
        if (mem_rsp_valid) begin
          hi_d       = mem_rsp_data;
          state_d    = ST_RESP;
          rsp_data_d = ext_data_s;
          rsp_err_d  = 1'b0;
        end else begin
          state_d = ST_WAIT1;
        end
      end
`endif

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers. Handshake outputs are registered
  // from the next state so each one is a clean flop output.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      addr_q          <= {ADDR_W{1'b0}};
      width_q         <= 3'b000;
      off_q           <= {OFF_W{1'b0}};
      lo_q            <= {DATA_W{1'b0}};
`ifdef LOAD_ALIGN_SPLIT_EN
      split_q         <= 1'b0;
      hi_q            <= {DATA_W{1'b0}};
`endif
      mem_req_addr_q  <= {ADDR_W{1'b0}};
      rsp_data_q      <= {DATA_W{1'b0}};
      rsp_err_q       <= 1'b0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      width_q         <= width_d;
      off_q           <= off_d;
      lo_q            <= lo_d;
`ifdef LOAD_ALIGN_SPLIT_EN
      split_q         <= split_d;
      hi_q            <= hi_d;
`endif
      mem_req_addr_q  <= mem_req_addr_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      req_ready_q     <= (state_d == ST_IDLE);
      mem_req_valid_q <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
      rsp_valid_q     <= (state_d == ST_RESP);
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
// Scoreboard bench for load_align_unit. A 64-bit instance carries most of the
// directed loads; a 32-bit instance covers the narrow-bus cases. Stimulus pushes
// expected bus addresses, bus beats and results into queues; a responder per
// instance answers bus reads and checks their addresses, and a monitor per
// instance pops and compares every returned result.
// -----------------------------------------------------------------------------
module tb_load_align_unit;
  import load_align_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;   // expected acceptance-to-rsp_valid cycles, -1 = skip
    int          acc;   // cycle the request was accepted
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 64-bit instance ----------------
  logic        rstn;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_width;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_data;
  logic        auto_v, inj_v, hold_rsp;
  logic [63:0] auto_d, inj_d;

  assign mem_rsp_valid = auto_v | inj_v;
  assign mem_rsp_data  = inj_v ? inj_d : auto_d;

  load_align_unit #(.DATA_W(64), .ADDR_W(64)) u_dut64 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_width(req_width),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // ---------------- 32-bit instance ----------------
  logic        req_valid32, req_ready32;
  logic [31:0] req_addr32;
  logic [2:0]  req_width32;
  logic        mem_req_valid32, mem_req_ready32;
  logic [31:0] mem_req_addr32;
  logic        mem_rsp_valid32;
  logic [31:0] mem_rsp_data32;
  logic        rsp_valid32, rsp_ready32, rsp_err32;
  logic [31:0] rsp_data32;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid32), .req_ready(req_ready32),
    .req_addr(req_addr32), .req_width(req_width32),
    .mem_req_valid(mem_req_valid32), .mem_req_ready(mem_req_ready32),
    .mem_req_addr(mem_req_addr32),
    .mem_rsp_valid(mem_rsp_valid32), .mem_rsp_data(mem_rsp_data32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32),
    .rsp_data(rsp_data32), .rsp_err(rsp_err32)
  );

  exp_t        sb_q[$];
  exp_t        sb32_q[$];
  logic [63:0] addr_q[$];
  logic [63:0] beat_q[$];
  logic [63:0] addr32_q[$];
  logic [63:0] beat32_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%h required none", name, act);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},     64'(req_ready),     64'd1);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_mem_req_addr"},  mem_req_addr,       64'd0);
    check({tag, "_rsp_valid"},     64'(rsp_valid),     64'd0);
    check({tag, "_rsp_data"},      rsp_data,           64'd0);
    check({tag, "_rsp_err"},       64'(rsp_err),       64'd0);
  endtask

  // Bus responder (64): checks each read address, answers one cycle later.
  initial begin : responder64
    logic        hs;
    logic [63:0] a;
    auto_v = 1'b0;
    auto_d = 64'd0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      a  = mem_req_addr;
      if (hs) begin
        if (addr_q.size() == 0) fail_now("bus_unexpected_req", a);
        else check("bus_addr", a, addr_q.pop_front());
      end
      @(posedge clk); #1;
      if (hs && !hold_rsp) begin
        auto_v = 1'b1;
        auto_d = (beat_q.size() != 0) ? beat_q.pop_front() : 64'd0;
      end else begin
        auto_v = 1'b0;
      end
    end
  end

  // Result monitor (64).
  initial begin : monitor64
    bit   seen;
    int   first;
    exp_t e;
    seen = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !seen) begin
        seen  = 1'b1;
        first = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        if (sb_q.size() == 0) begin
          fail_now("rsp_unexpected", rsp_data);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (e.lat >= 0) check("latency", 64'(first - e.acc), 64'(e.lat));
        end
      end
    end
  end

  // Bus responder (32).
  initial begin : responder32
    logic        hs;
    logic [31:0] a;
    mem_rsp_valid32 = 1'b0;
    mem_rsp_data32  = 32'd0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid32 && mem_req_ready32;
      a  = mem_req_addr32;
      if (hs) begin
        if (addr32_q.size() == 0) fail_now("bus32_unexpected_req", 64'(a));
        else check("bus32_addr", 64'(a), addr32_q.pop_front());
      end
      @(posedge clk); #1;
      if (hs) begin
        mem_rsp_valid32 = 1'b1;
        mem_rsp_data32  = (beat32_q.size() != 0) ? beat32_q.pop_front() : 32'd0;
      end else begin
        mem_rsp_valid32 = 1'b0;
      end
    end
  end

  // Result monitor (32).
  initial begin : monitor32
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid32 && rsp_ready32) begin
        if (sb32_q.size() == 0) begin
          fail_now("rsp32_unexpected", 64'(rsp_data32));
        end else begin
          e = sb32_q.pop_front();
          check("rsp32_data", 64'(rsp_data32), e.data);
          check("rsp32_err", 64'(rsp_err32), 64'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic [63:0] addr, input logic [2:0] w, output int acc);
    bit done;
    done = 1'b0;
    acc  = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_width = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin done = 1'b1; acc = cyc; end
    end
    if (!done) fail_now("accept_timeout", addr);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_load(input logic [63:0] addr, input logic [2:0] w,
                          input logic [63:0] d, input logic err, input int lat);
    int   acc;
    exp_t e;
    issue(addr, w, acc);
    e.data = d; e.err = err; e.lat = lat; e.acc = acc;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      fail_now("rsp_timeout", 64'(sb_q.size()));
      sb_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic run_load32(input logic [31:0] addr, input logic [2:0] w,
                            input logic [63:0] d, input logic err);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(posedge clk); #1;
    req_valid32 = 1'b1; req_addr32 = addr; req_width32 = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready32) done = 1'b1;
    end
    if (!done) fail_now("accept32_timeout", 64'(addr));
    @(posedge clk); #1;
    req_valid32 = 1'b0;
    e.data = d; e.err = err; e.lat = -1; e.acc = 0;
    sb32_q.push_back(e);
    for (int i = 0; i < 100 && sb32_q.size() != 0; i++) @(posedge clk);
    if (sb32_q.size() != 0) begin
      fail_now("rsp32_timeout", 64'(sb32_q.size()));
      sb32_q.delete();
    end
    @(posedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  acc;
    bit  seen;
    exp_t e;
    rstn = 1'b0; hold_rsp = 1'b0; inj_v = 1'b0; inj_d = 64'd0;
    req_valid = 1'b0; req_addr = 64'd0; req_width = 3'b000;
    mem_req_ready = 1'b1; rsp_ready = 1'b1;
    req_valid32 = 1'b0; req_addr32 = 32'd0; req_width32 = 3'b000;
    mem_req_ready32 = 1'b1; rsp_ready32 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset32_req_ready", 64'(req_ready32), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Aligned signed word, with latency
    addr_q.push_back(64'h1000); beat_q.push_back(64'h80000000_12345678);
    run_load(64'h1004, MEM_WORD, 64'hFFFFFFFF_80000000, 1'b0, 3);
    drain();

    // Byte at the last lane, unsigned then signed
    addr_q.push_back(64'h2000); beat_q.push_back(64'hAB00_0000_0000_0000);
    run_load(64'h2007, MEM_UNBYTE, 64'h0000_0000_0000_00AB, 1'b0, 3);
    drain();
    addr_q.push_back(64'h2000); beat_q.push_back(64'hAB00_0000_0000_0000);
    run_load(64'h2007, MEM_BYTE, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 3);
    drain();

    // Halves/words and full-width codes
    addr_q.push_back(64'h2000); beat_q.push_back(64'h0000_0000_8001_0000);
    run_load(64'h2002, MEM_HALF, 64'hFFFF_FFFF_FFFF_8001, 1'b0, -1);
    drain();
    addr_q.push_back(64'h2000); beat_q.push_back(64'h8765_4321_0000_0000);
    run_load(64'h2004, MEM_UNWORD, 64'h0000_0000_8765_4321, 1'b0, -1);
    drain();
    addr_q.push_back(64'h4000); beat_q.push_back(64'h8123_4567_89AB_CDEF);
    run_load(64'h4000, MEM_DOUBLE, 64'h8123_4567_89AB_CDEF, 1'b0, 3);
    drain();
    addr_q.push_back(64'h4000); beat_q.push_back(64'h8123_4567_89AB_CDEF);
    run_load(64'h4000, MEM_NO, 64'h8123_4567_89AB_CDEF, 1'b0, -1);
    drain();

    // Straddling loads
`ifdef LOAD_ALIGN_SPLIT_EN
    addr_q.push_back(64'h1000); beat_q.push_back(64'hBEEF_0000_0000_0000);
    addr_q.push_back(64'h1008); beat_q.push_back(64'h0000_0000_0000_1234);
    run_load(64'h1006, MEM_WORD, 64'h0000_0000_1234_BEEF, 1'b0, 5);
    drain();
    addr_q.push_back(64'h3000); beat_q.push_back(64'h1122_3344_5566_7788);
    addr_q.push_back(64'h3008); beat_q.push_back(64'h99AA_BBCC_DDEE_FF00);
    run_load(64'h3005, MEM_NO, 64'hCCDD_EEFF_0011_2233, 1'b0, 5);
    drain();
    addr_q.push_back(64'h50F0); beat_q.push_back(64'hFE00_0000_0000_0000);
    addr_q.push_back(64'h50F8); beat_q.push_back(64'h0000_0000_0000_00FF);
    run_load(64'h50F7, MEM_HALF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, -1);
    drain();
    addr_q.push_back(64'hFFFF_FFFF_FFFF_FFF8); beat_q.push_back(64'h0102_0000_0000_0000);
    addr_q.push_back(64'h0000_0000_0000_0000); beat_q.push_back(64'h0000_0000_0000_0403);
    run_load(64'hFFFF_FFFF_FFFF_FFFE, MEM_WORD, 64'h0000_0000_0403_0102, 1'b0, 5);
    drain();
`else
    run_load(64'h1006, MEM_WORD, 64'd0, 1'b1, 1);
    drain();
    run_load(64'h3005, MEM_NO, 64'd0, 1'b1, 1);
    drain();
    run_load(64'h50F7, MEM_HALF, 64'd0, 1'b1, -1);
    drain();
`endif

    // Backpressure on bus request and on result
    mem_req_ready = 1'b0; rsp_ready = 1'b0;
    addr_q.push_back(64'h1010); beat_q.push_back(64'h0000_0000_0000_00C3);
    issue(64'h1010, MEM_UNBYTE, acc);
    e.data = 64'h0000_0000_0000_00C3; e.err = 1'b0; e.lat = -1; e.acc = acc;
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_mem_req_valid", 64'(mem_req_valid), 64'd1);
      check("bp_mem_req_addr", mem_req_addr, 64'h1010);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) fail_now("bp_rsp_timeout", 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 64'h6000; req_width = MEM_WORD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_data", rsp_data, 64'h0000_0000_0000_00C3);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    // Reset while waiting for read data, then a late response
    hold_rsp = 1'b1;
    addr_q.push_back(64'h1000);
    issue(64'h1004, MEM_WORD, acc);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; inj_v = 1'b1; inj_d = 64'h5555_6666_7777_8888;
    @(negedge clk);
    check_idle("rst_mid");
    @(posedge clk); #1;
    inj_v = 1'b0; hold_rsp = 1'b0;
    @(negedge clk);
    check_idle("late_rsp");
    addr_q.push_back(64'h2000); beat_q.push_back(64'h0000_0000_0000_7F00);
    run_load(64'h2001, MEM_BYTE, 64'h0000_0000_0000_007F, 1'b0, 3);
    drain();

    // 32-bit bus
    run_load32(32'h10, MEM_DOUBLE, 64'd0, 1'b1);
`ifdef LOAD_ALIGN_SPLIT_EN
    addr32_q.push_back(64'h0); beat32_q.push_back(64'h1100_0000);
    addr32_q.push_back(64'h4); beat32_q.push_back(64'h0000_0022);
    run_load32(32'h3, MEM_HALF, 64'h0000_2211, 1'b0);
`else
    run_load32(32'h3, MEM_HALF, 64'd0, 1'b1);
`endif
    addr32_q.push_back(64'h8); beat32_q.push_back(64'h8000_0001);
    run_load32(32'h8, MEM_WORD, 64'h8000_0001, 1'b0);
    addr32_q.push_back(64'h8); beat32_q.push_back(64'h0000_8000);
    run_load32(32'h9, MEM_BYTE, 64'hFFFF_FF80, 1'b0);
    addr32_q.push_back(64'h8); beat32_q.push_back(64'hCAFE_F00D);
    run_load32(32'h8, MEM_NO, 64'hCAFE_F00D, 1'b0);

    repeat (3) @(posedge clk);
    check("addr_left", 64'(addr_q.size()), 64'd0);
    check("addr32_left", 64'(addr32_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
